// File: rtl/jump_charge_meter.sv
// Jump charge meter: times a button press in charge ticks, scales the tick count to a
// saturated jump distance and strobes end_of_jump with the distance valid.
module jump_charge_meter #(
    parameter int unsigned TICK_DIV    = 500000,
    parameter int unsigned MAX_TICKS   = 300,
    parameter int unsigned MIN_TICKS   = 2,
    parameter int unsigned DIST_GAIN   = 1,
    parameter int unsigned DIST_SHIFT  = 0,
    parameter int unsigned BLINK_TICKS = 25,
    parameter int unsigned DIST_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  jump_btn,
    input  logic                  jump_busy,
    output logic [DIST_WIDTH-1:0] jump_dist,
    output logic                  end_of_jump,
    output logic [15:0]           press_time,
    output logic                  light_on,
    output logic                  light_blink
);

    localparam int unsigned TW  = $clog2(MAX_TICKS + 1);
    localparam int unsigned PSW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned BW  = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
    // Wide enough that ticks * DIST_GAIN never truncates before saturation.
    localparam int unsigned PW  = TW + 32 + DIST_WIDTH;
    localparam logic [PW-1:0] DistMax = {{(PW - DIST_WIDTH){1'b0}}, {DIST_WIDTH{1'b1}}};

    typedef enum logic [1:0] {StIdle, StCharge, StCalc, StFire} state_e;

    state_e           state_q;
    logic             btn_q;
    logic [PSW-1:0]   prescaler_q;
    logic [TW-1:0]    ticks_q;
    logic [BW-1:0]    blink_cnt_q;

    logic             rise;
    logic             tick_wrap;
    logic             saturated;
    logic [TW-1:0]    ticks_inc;
    logic [PW-1:0]    prod;
    logic [PW-1:0]    scaled;
    logic [DIST_WIDTH-1:0] dist_sat;

    always_comb begin
        rise      = jump_btn & ~btn_q;
        tick_wrap = (prescaler_q == PSW'(TICK_DIV - 1));
        saturated = (ticks_q == TW'(MAX_TICKS));
        ticks_inc = saturated ? ticks_q : ticks_q + TW'(1);
        prod      = PW'(ticks_q) * PW'(DIST_GAIN);
        scaled    = prod >> DIST_SHIFT;
        dist_sat  = (scaled > DistMax) ? {DIST_WIDTH{1'b1}} : scaled[DIST_WIDTH-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            btn_q       <= 1'b1;
            prescaler_q <= '0;
            ticks_q     <= '0;
            blink_cnt_q <= '0;
            jump_dist   <= '0;
            end_of_jump <= 1'b0;
            press_time  <= '0;
            light_on    <= 1'b0;
            light_blink <= 1'b0;
        end else begin
            btn_q       <= jump_btn;
            end_of_jump <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (rise && !jump_busy) begin
                        state_q     <= StCharge;
                        prescaler_q <= '0;
                        ticks_q     <= '0;
                        blink_cnt_q <= '0;
                        press_time  <= '0;
                        light_on    <= 1'b1;
                    end
                end
                StCharge: begin
                    if (!jump_btn) begin
                        light_on    <= 1'b0;
                        light_blink <= 1'b0;
                        state_q     <= (32'(ticks_q) < MIN_TICKS) ? StIdle : StCalc;
                    end else if (tick_wrap) begin
                        prescaler_q <= '0;
                        ticks_q     <= ticks_inc;
                        press_time  <= 16'(ticks_inc);
                        // Blink only counts wraps that occur while already saturated.
                        if (saturated) begin
                            if (blink_cnt_q == BW'(BLINK_TICKS - 1)) begin
                                blink_cnt_q <= '0;
                                light_blink <= ~light_blink;
                            end else begin
                                blink_cnt_q <= blink_cnt_q + BW'(1);
                            end
                        end
                    end else begin
                        prescaler_q <= prescaler_q + PSW'(1);
                    end
                end
                StCalc: begin
                    jump_dist <= dist_sat;
                    state_q   <= StFire;
                end
                StFire: begin
                    end_of_jump <= 1'b1;
                    state_q     <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_jump_charge_meter.sv
// Scoreboard bench for jump_charge_meter: expected distances are queued at release and
// popped when end_of_jump fires; a DIST_WIDTH=4 twin checks distance saturation.
module tb_jump_charge_meter;

    localparam int unsigned TickDiv = 4;
    localparam int unsigned MaxT    = 10;
    localparam int unsigned MinT    = 2;
    localparam int unsigned Gain    = 3;
    localparam int unsigned Blink   = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        jump_btn;
    logic        jump_busy;
    logic [15:0] jump_dist;
    logic        end_of_jump;
    logic [15:0] press_time;
    logic        light_on;
    logic        light_blink;
    logic [3:0]  jump_dist4;
    logic        end_of_jump4;
    logic [15:0] press_time4;
    logic        light_on4;
    logic        light_blink4;

    typedef struct {
        int unsigned d16;
        int unsigned d4;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    jump_charge_meter #(
        .TICK_DIV(TickDiv), .MAX_TICKS(MaxT), .MIN_TICKS(MinT), .DIST_GAIN(Gain),
        .DIST_SHIFT(0), .BLINK_TICKS(Blink), .DIST_WIDTH(16)
    ) dut (
        .clk(clk), .rst(rst), .jump_btn(jump_btn), .jump_busy(jump_busy),
        .jump_dist(jump_dist), .end_of_jump(end_of_jump), .press_time(press_time),
        .light_on(light_on), .light_blink(light_blink)
    );

    jump_charge_meter #(
        .TICK_DIV(TickDiv), .MAX_TICKS(MaxT), .MIN_TICKS(MinT), .DIST_GAIN(Gain),
        .DIST_SHIFT(0), .BLINK_TICKS(Blink), .DIST_WIDTH(4)
    ) dut4 (
        .clk(clk), .rst(rst), .jump_btn(jump_btn), .jump_busy(jump_busy),
        .jump_dist(jump_dist4), .end_of_jump(end_of_jump4), .press_time(press_time4),
        .light_on(light_on4), .light_blink(light_blink4)
    );

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && end_of_jump) begin
            if (sb.size() == 0) begin
                check("spurious_strobe", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("jump_dist", jump_dist, e.d16);
                check("jump_dist_w4", jump_dist4, e.d4);
                check("eoj_w4", end_of_jump4, 1);
            end
        end
    end

    // Press for n CHARGE cycles then release; checks lights, press_time and strobe timing.
    task automatic press(input int unsigned n);
        int unsigned t, w, d;
        exp_t e;
        t = 0;
        @(negedge clk) jump_btn = 1'b1;
        for (int unsigned k = 0; k <= n; k++) begin
            @(negedge clk);
            t = (k / TickDiv > MaxT) ? MaxT : k / TickDiv;
            w = (k / TickDiv > MaxT) ? k / TickDiv - MaxT : 0;
            check("light_on_hold", light_on, 1);
            check("light_blink", light_blink, (w / Blink) % 2);
        end
        check("press_time", press_time, t);
        jump_btn = 1'b0;
        if (t >= MinT) begin
            d     = t * Gain;
            e.d16 = (d > 65535) ? 65535 : d;
            e.d4  = (d > 15) ? 15 : d;
            sb.push_back(e);
        end
        @(negedge clk);
        check("eoj_n0", end_of_jump, 0);
        check("light_off", light_on, 0);
        check("blink_off", light_blink, 0);
        @(negedge clk);
        check("eoj_n1", end_of_jump, 0);
        @(negedge clk);
        check("eoj_n2", end_of_jump, (t >= MinT) ? 1 : 0);
        @(negedge clk);
        check("eoj_n3", end_of_jump, 0);
        check("press_time_held", press_time, t);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_dist"}, jump_dist, 0);
        check({tag, "_eoj"}, end_of_jump, 0);
        check({tag, "_ptime"}, press_time, 0);
        check({tag, "_lon"}, light_on, 0);
        check({tag, "_blink"}, light_blink, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        jump_btn  = 1'b0;
        jump_busy = 1'b0;
        repeat (3) @(negedge clk);
        check_zero("reset");
        check("reset_dist_w4", jump_dist4, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        press(25);
        check("dist_after_t2", jump_dist, 18);

        press(5);
        check("dist_unchanged", jump_dist, 18);

        press(60);
        check("dist_saturated_ticks", jump_dist, 30);
        check("dist_w4_saturated", jump_dist4, 15);

        // Press while busy, busy drops mid-hold: must not charge.
        jump_busy = 1'b1;
        @(negedge clk) jump_btn = 1'b1;
        repeat (4) @(negedge clk);
        check("busy_no_charge", light_on, 0);
        jump_busy = 1'b0;
        repeat (6) @(negedge clk);
        check("busy_drop_no_charge", light_on, 0);
        jump_btn = 1'b0;
        repeat (4) @(negedge clk);
        check("busy_ptime_held", press_time, 10);
        press(9);
        check("dist_after_busy", jump_dist, 6);

        // Reset in mid-charge with the button still held.
        @(negedge clk) jump_btn = 1'b1;
        repeat (13) @(negedge clk);
        check("pre_reset_charging", light_on, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_zero("midreset");
        repeat (10) @(negedge clk);
        check("held_no_charge", light_on, 0);
        check("held_ptime", press_time, 0);
        jump_btn = 1'b0;
        repeat (4) @(negedge clk);
        press(8);
        check("dist_after_reset", jump_dist, 6);

        repeat (3) @(negedge clk);
        check("sb_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/jump_charge_meter.md
Name: jump_charge_meter

Overview:
Converts the debounced jump button level into a jump distance for the game FSM. Measures press duration in fixed charge ticks, scales ticks to a saturated distance and issues a one-cycle end_of_jump strobe with jump_dist valid. Sits between the button debouncer and the game FSM. Also drives the press-time readout and the charge lights.

Parameters:
TICK_DIV, 500000, clk cycles per charge tick (10 ms at 50 MHz)
MAX_TICKS, 300, tick count saturation value
MIN_TICKS, 2, presses shorter than this are discarded
DIST_GAIN, 1, multiplier applied to ticks
DIST_SHIFT, 0, right shift applied after multiply
BLINK_TICKS, 25, ticks per light_blink half-period once saturated
DIST_WIDTH, 16, width of jump_dist

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous reset, active-high
jump_btn  in  1  debounced button level, 1 = pressed
jump_busy  in  1  FSM jump in progress; new presses ignored while 1
jump_dist  out  DIST_WIDTH  scaled distance, registered, held until next strobe
end_of_jump  out  1  one-cycle strobe, jump_dist valid in the same cycle
press_time  out  16  current/last press tick count
light_on  out  1  1 while in CHARGE
light_blink  out  1  blink output once ticks saturate

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset: state IDLE, prescaler/ticks/blink counter 0, jump_dist 0, end_of_jump 0, press_time 0, light_on 0, light_blink 0; btn_q (previous jump_btn) resets to 1, so a button held through reset needs release and re-press.
- Rising edge = jump_btn 1 and btn_q 0; btn_q registered every cycle.
- States: IDLE, CHARGE, CALC, FIRE.
- IDLE: rising edge and jump_busy 0 -> CHARGE; prescaler, ticks, blink counter cleared; press_time 0. Edge while busy is dropped; a press still held when busy falls does not start CHARGE.
- CHARGE: light_on 1. Each cycle prescaler++; when prescaler = TICK_DIV-1, prescaler <= 0, ticks <= min(ticks+1, MAX_TICKS). After 4k CHARGE cycles with TICK_DIV=4, ticks = k. press_time tracks ticks, zero-extended or truncated to 16 bits.
- Saturation: when ticks = MAX_TICKS, blink counter counts tick wraps and toggles light_blink every BLINK_TICKS wraps. Otherwise light_blink is 0.
- jump_btn sampled 0 in CHARGE:
  - ticks < MIN_TICKS -> IDLE, no strobe, jump_dist unchanged.
  - Otherwise -> CALC.
  - light_on and light_blink go 0 on exit.
- CALC: jump_dist <= min((ticks*DIST_GAIN) >> DIST_SHIFT, 2^DIST_WIDTH-1). Product is full width, with no intermediate truncation. -> FIRE.
- FIRE: end_of_jump 1 for exactly this cycle -> IDLE. Release sampled at edge N gives end_of_jump high in cycle N+2 (after edges N+1 and N+2).
- press_time holds its final value until the next accepted press.
- jump_busy is ignored outside IDLE; a charge in progress is never aborted by busy.
- Reset mid-operation: immediate return to reset values, no strobe.

Test Plan:
All tests use TICK_DIV=4, MAX_TICKS=10, MIN_TICKS=2, DIST_GAIN=3, DIST_SHIFT=0, BLINK_TICKS=2, DIST_WIDTH=16 unless noted.
1. Assert rst 3 cycles with jump_btn 0 -> all outputs 0, including press_time and jump_dist.
2. Press, hold 25 CHARGE cycles, release -> press_time 6, light_on 1 during hold, jump_dist 18, end_of_jump high exactly 1 cycle, 2 cycles after release sample.
3. Press for 5 CHARGE cycles -> ticks 1, no end_of_jump, jump_dist stays 18, press_time 1.
4. Hold 60 cycles -> press_time 10, light_blink toggles every 8 cycles after saturation, jump_dist 30; repeat with DIST_WIDTH=4 -> jump_dist 15.
5. jump_busy 1, press and hold, drop busy mid-hold, release -> no CHARGE, no strobe; a fresh press then charges normally.
6. Hold button 12 CHARGE cycles, assert rst one cycle while still held -> outputs 0, light_on 0; continued hold gives no charge; release then press 8 cycles -> jump_dist 6.
